// File: rtl/proc_subsystem_pkg.sv
// proc_subsystem_pkg: command/reply byte codes and parser state for the UART-to-GPIO bridge.
package proc_subsystem_pkg;
  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_K   = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;
  typedef enum logic [1:0] {IDLE, WDATA, RESP} parse_state_e;
endpackage

// File: rtl/proc_uart.sv
// proc_uart: 8N1 UART receiver and transmitter with byte-valid / tx-start / tx-busy handshakes.
module proc_uart
  import proc_subsystem_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 87
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_busy_o
);
  localparam logic [15:0] FULL = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF = 16'(BAUD_DIV / 2 - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  rx_state_e   rx_st_q;
  logic [2:0]  rx_sync_q;
  logic [15:0] rx_cnt_q, tx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [3:0]  tx_bit_q;
  logic [8:0]  tx_sh_q;
  logic        rx_s, rx_tick, tx_tick;
  // bits [1:0] synchronize RX, bit [2] holds the previous synced value for edge detection
  assign rx_s    = rx_sync_q[1];
  assign rx_tick = rx_cnt_q == FULL;
  assign tx_tick = tx_cnt_q == FULL;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rx_sync_q  <= '1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[1:0], rx_i};
      rx_valid_o <= 1'b0;
      rx_cnt_q   <= rx_tick ? '0 : rx_cnt_q + 16'd1;
      case (rx_st_q)
        RX_IDLE: if (rx_sync_q[2] && !rx_s) begin
          rx_st_q  <= RX_START;
          rx_cnt_q <= '0;
        end
        RX_START: if (rx_cnt_q == HALF) begin
          rx_st_q  <= rx_s ? RX_IDLE : RX_DATA;
          rx_cnt_q <= '0;
        end
        RX_DATA: if (rx_tick) begin
          rx_data_o <= {rx_s, rx_data_o[7:1]};
          rx_bit_q  <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
        end
        default: if (rx_tick) begin
          rx_valid_o <= rx_s;
          rx_st_q    <= RX_IDLE;
        end
      endcase
    end
  // the shifter refills with ones, so the stop bit and the idle line come for free
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      tx_o      <= 1'b1;
      tx_busy_o <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '1;
    end else if (!tx_busy_o) begin
      if (tx_start_i) begin
        tx_o      <= 1'b0;
        tx_sh_q   <= {1'b1, tx_data_i};
        tx_bit_q  <= 4'd9;
        tx_cnt_q  <= '0;
        tx_busy_o <= 1'b1;
      end
    end else if (tx_tick) begin
      tx_cnt_q  <= '0;
      tx_o      <= tx_sh_q[0];
      tx_sh_q   <= {1'b1, tx_sh_q[8:1]};
      tx_bit_q  <= tx_bit_q - 4'd1;
      tx_busy_o <= tx_bit_q != 4'd0;
    end else begin
      tx_cnt_q <= tx_cnt_q + 16'd1;
    end
endmodule

// File: rtl/proc_subsystem.sv
// proc_subsystem: board shell with UART-to-GPIO command bridge, JTAG bypass and idle MDDR drive.
// Define PROC_SUBSYSTEM_DDR_INIT_EN to enable the MDDR reset/CKE power-up sequence and clock.
module proc_subsystem
  import proc_subsystem_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = 87,
  parameter int unsigned DDR_RST_CYC = 2000,
  parameter int unsigned DDR_CKE_CYC = 5000
) (
  input  logic        CLK0_PAD,
  input  logic        DEVRST_N,
  input  logic        RX,
  output logic        TX,
  input  logic [1:0]  GPIO_IN,
  output logic [3:0]  GPIO_OUT,
  input  logic        TCK,
  input  logic        TMS,
  input  logic        TDI,
  input  logic        TRSTB,
  output logic        TDO,
  input  logic        MDDR_DQS_TMATCH_0_IN,
  output logic        MDDR_DQS_TMATCH_0_OUT,
  output logic        MDDR_CLK,
  output logic        MDDR_CLK_N,
  output logic        MDDR_CKE,
  output logic        MDDR_CS_N,
  output logic        MDDR_ODT,
  output logic        MDDR_RAS_N,
  output logic        MDDR_CAS_N,
  output logic        MDDR_WE_N,
  output logic        MDDR_RESET_N,
  output logic [15:0] MDDR_ADDR,
  output logic [2:0]  MDDR_BA,
  inout  wire  [15:0] MDDR_DQ,
  inout  wire  [1:0]  MDDR_DQS,
  inout  wire  [1:0]  MDDR_DQS_N,
  inout  wire  [1:0]  MDDR_DM_RDQS
);
  parse_state_e st_q;
  logic [1:0] gpio_s1_q, gpio_s2_q, tdi_q, trst_q;
  logic [2:0] tck_q;
  logic [3:0] gpio_out_q;
  logic [7:0] tx_data_q, rx_data;
  logic       tx_start_q, bypass_q, tdo_q, rx_valid, tx_busy, unused_ok;
  proc_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk_i     (CLK0_PAD),
    .rst_ni    (DEVRST_N),
    .rx_i      (RX),
    .tx_o      (TX),
    .rx_data_o (rx_data),
    .rx_valid_o(rx_valid),
    .tx_start_i(tx_start_q),
    .tx_data_i (tx_data_q),
    .tx_busy_o (tx_busy)
  );
  // RESP also waits on tx_start_q because tx_busy rises one cycle after the start pulse
  always_ff @(posedge CLK0_PAD or negedge DEVRST_N)
    if (!DEVRST_N) begin
      st_q       <= IDLE;
      gpio_s1_q  <= '0;
      gpio_s2_q  <= '0;
      gpio_out_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      gpio_s1_q  <= GPIO_IN;
      gpio_s2_q  <= gpio_s1_q;
      tx_start_q <= 1'b0;
      case (st_q)
        IDLE: if (rx_valid) begin
          st_q       <= rx_data == CMD_W ? WDATA : RESP;
          tx_start_q <= rx_data != CMD_W;
          tx_data_q  <= rx_data == CMD_R ? {6'b0, gpio_s2_q} : RSP_ERR;
        end
        WDATA: if (rx_valid) begin
          st_q       <= RESP;
          gpio_out_q <= rx_data[3:0];
          tx_start_q <= 1'b1;
          tx_data_q  <= RSP_K;
        end
        default: if (!tx_start_q && !tx_busy) st_q <= IDLE;
      endcase
    end
  // TDI shares TCK's two-stage delay so the captured bit lines up with the detected edge
  always_ff @(posedge CLK0_PAD or negedge DEVRST_N)
    if (!DEVRST_N) begin
      tck_q    <= '0;
      tdi_q    <= '0;
      trst_q   <= '0;
      bypass_q <= 1'b0;
      tdo_q    <= 1'b0;
    end else begin
      tck_q  <= {tck_q[1:0], TCK};
      tdi_q  <= {tdi_q[0], TDI};
      trst_q <= {trst_q[0], TRSTB};
      if (!trst_q[1]) begin
        bypass_q <= 1'b0;
        tdo_q    <= 1'b0;
      end else begin
        if (tck_q[1] && !tck_q[2]) bypass_q <= tdi_q[1];
        if (!tck_q[1] && tck_q[2]) tdo_q <= bypass_q;
      end
    end
  assign GPIO_OUT              = gpio_out_q;
  assign TDO                   = tdo_q;
  assign MDDR_DQS_TMATCH_0_OUT = MDDR_DQS_TMATCH_0_IN;
  assign MDDR_CS_N             = 1'b1;
  assign MDDR_RAS_N            = 1'b1;
  assign MDDR_CAS_N            = 1'b1;
  assign MDDR_WE_N             = 1'b1;
  assign MDDR_ODT              = 1'b0;
  assign MDDR_ADDR             = '0;
  assign MDDR_BA               = '0;
  assign MDDR_DQ               = 'z;
  assign MDDR_DQS              = 'z;
  assign MDDR_DQS_N            = 'z;
  assign MDDR_DM_RDQS          = 'z;
  assign unused_ok = ^{TMS, MDDR_DQ, MDDR_DQS, MDDR_DQS_N, MDDR_DM_RDQS, DDR_RST_CYC[0], DDR_CKE_CYC[0]};
`ifdef PROC_SUBSYSTEM_DDR_INIT_EN
  localparam logic [31:0] RST_AT = 32'(DDR_RST_CYC - 1);
  localparam logic [31:0] CKE_AT = 32'(DDR_RST_CYC + DDR_CKE_CYC - 1);
  logic [31:0] ddr_cnt_q;
  logic        ddr_rst_n_q, ddr_cke_q, ddr_clk_q;
  always_ff @(posedge CLK0_PAD or negedge DEVRST_N)
    if (!DEVRST_N) begin
      ddr_cnt_q   <= '0;
      ddr_rst_n_q <= 1'b0;
      ddr_cke_q   <= 1'b0;
      ddr_clk_q   <= 1'b0;
    end else begin
      if (ddr_cnt_q != CKE_AT) ddr_cnt_q <= ddr_cnt_q + 32'd1;
      ddr_rst_n_q <= ddr_rst_n_q | (ddr_cnt_q == RST_AT);
      ddr_cke_q   <= ddr_cke_q | (ddr_cnt_q == CKE_AT);
      ddr_clk_q   <= ddr_cke_q & ~ddr_clk_q;
    end
  assign MDDR_RESET_N = ddr_rst_n_q;
  assign MDDR_CKE     = ddr_cke_q;
  assign MDDR_CLK     = ddr_clk_q;
  assign MDDR_CLK_N   = ~ddr_clk_q;
`else
  assign MDDR_RESET_N = 1'b0;
  assign MDDR_CKE     = 1'b0;
  assign MDDR_CLK     = 1'b0;
  assign MDDR_CLK_N   = 1'b1;
`endif
endmodule

// File: tb/tb_proc_subsystem.sv
// tb_proc_subsystem: directed self-checking bench for the UART bridge, JTAG bypass and MDDR pads.
module tb_proc_subsystem;
  localparam int B = 16;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, tck = 1'b0, tms = 1'b0, tdi = 1'b0, trstb = 1'b1, tm_in = 1'b0;
  logic [1:0] gpio_in = 2'b00;
  logic tx, tdo, tm_out, m_clk, m_clk_n, m_cke, m_cs_n, m_odt, m_ras_n, m_cas_n, m_we_n, m_rst_n;
  logic [3:0] gpio_out;
  logic [15:0] m_addr;
  logic [2:0] m_ba;
  wire [15:0] m_dq;
  wire [1:0] m_dqs, m_dqs_n, m_dm;
  logic [7:0] rx_byte;
  logic rx_got;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  proc_subsystem #(.BAUD_DIV(B), .DDR_RST_CYC(20), .DDR_CKE_CYC(30)) dut (
    .CLK0_PAD(clk), .DEVRST_N(rst_n), .RX(rx), .TX(tx), .GPIO_IN(gpio_in), .GPIO_OUT(gpio_out),
    .TCK(tck), .TMS(tms), .TDI(tdi), .TRSTB(trstb), .TDO(tdo),
    .MDDR_DQS_TMATCH_0_IN(tm_in), .MDDR_DQS_TMATCH_0_OUT(tm_out),
    .MDDR_CLK(m_clk), .MDDR_CLK_N(m_clk_n), .MDDR_CKE(m_cke), .MDDR_CS_N(m_cs_n), .MDDR_ODT(m_odt),
    .MDDR_RAS_N(m_ras_n), .MDDR_CAS_N(m_cas_n), .MDDR_WE_N(m_we_n), .MDDR_RESET_N(m_rst_n),
    .MDDR_ADDR(m_addr), .MDDR_BA(m_ba), .MDDR_DQ(m_dq), .MDDR_DQS(m_dqs), .MDDR_DQS_N(m_dqs_n),
    .MDDR_DM_RDQS(m_dm)
  );
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic uart_send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cycles(B);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(B);
    end
    rx = stop;
    cycles(3 * B / 4);
    rx = 1'b1;
  endtask
  task automatic uart_recv();
    int t = 0;
    rx_byte = '0;
    rx_got = 1'b0;
    while (tx === 1'b1 && t < 20 * B) begin
      @(negedge clk);
      t++;
    end
    if (tx !== 1'b0) return;
    cycles(B / 2);
    if (tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      cycles(B);
      rx_byte[i] = tx;
    end
    cycles(B);
    rx_got = tx;
  endtask
  task automatic xact(input logic [7:0] b, input logic stop);
    fork
      uart_send(b, stop);
      uart_recv();
    join
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    cycles(10);
    checks++; if ({tx, gpio_out, tdo} !== 6'b1_0000_0) begin errors++; $display("FAIL reset_core: tx/gpio/tdo=%b required 100000", {tx, gpio_out, tdo}); end
    checks++; if ({m_rst_n, m_cke, m_odt, m_cs_n, m_ras_n, m_cas_n, m_we_n, m_clk, m_clk_n} !== 9'b000_1111_01) begin errors++; $display("FAIL reset_ddr_ctl: got %b required 000111101", {m_rst_n, m_cke, m_odt, m_cs_n, m_ras_n, m_cas_n, m_we_n, m_clk, m_clk_n}); end
    checks++; if ({m_addr, m_ba} !== 19'h0) begin errors++; $display("FAIL reset_ddr_addr: got %h required 0", {m_addr, m_ba}); end
    rst_n = 1'b1;
    cycles(3);
    checks++; if ({tx, gpio_out, tdo, m_cs_n, m_odt} !== 8'b1_0000_0_1_0) begin errors++; $display("FAIL after_release: got %b required 10000010", {tx, gpio_out, tdo, m_cs_n, m_odt}); end
    tm_in = 1'b1;
    #1;
    checks++; if (tm_out !== 1'b1) begin errors++; $display("FAIL tmatch_hi: got %b required 1", tm_out); end
    tm_in = 1'b0;
    #1;
    checks++; if (tm_out !== 1'b0) begin errors++; $display("FAIL tmatch_lo: got %b required 0", tm_out); end
  endtask
  task automatic test_ddr();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
`ifdef PROC_SUBSYSTEM_DDR_INIT_EN
    cycles(19);
    checks++; if (m_rst_n !== 1'b0) begin errors++; $display("FAIL ddr_rst_early: got %b required 0 at cycle 19", m_rst_n); end
    cycles(1);
    checks++; if ({m_rst_n, m_cke} !== 2'b10) begin errors++; $display("FAIL ddr_rst_rise: got %b required 10 at cycle 20", {m_rst_n, m_cke}); end
    cycles(29);
    checks++; if (m_cke !== 1'b0) begin errors++; $display("FAIL ddr_cke_early: got %b required 0 at cycle 49", m_cke); end
    cycles(1);
    checks++; if ({m_cke, m_clk, m_clk_n} !== 3'b101) begin errors++; $display("FAIL ddr_cke_rise: got %b required 101 at cycle 50", {m_cke, m_clk, m_clk_n}); end
    cycles(1);
    checks++; if ({m_clk, m_clk_n, m_cs_n} !== 3'b101) begin errors++; $display("FAIL ddr_clk_hi: got %b required 101", {m_clk, m_clk_n, m_cs_n}); end
    cycles(1);
    checks++; if ({m_clk, m_clk_n} !== 2'b01) begin errors++; $display("FAIL ddr_clk_lo: got %b required 01", {m_clk, m_clk_n}); end
`else
    cycles(60);
    checks++; if ({m_rst_n, m_cke, m_clk, m_clk_n} !== 4'b0001) begin errors++; $display("FAIL ddr_static: got %b required 0001", {m_rst_n, m_cke, m_clk, m_clk_n}); end
`endif
  endtask
  task automatic test_write();
    xact(8'h57, 1'b1);
    checks++; if (rx_got !== 1'b0) begin errors++; $display("FAIL write_cmd_noreply: got reply %h required none", rx_byte); end
    checks++; if (gpio_out !== 4'h0) begin errors++; $display("FAIL write_cmd_gpio: got %h required 0", gpio_out); end
    xact(8'hA5, 1'b1);
    checks++; if ({rx_got, rx_byte} !== {1'b1, 8'h4B}) begin errors++; $display("FAIL write_reply: got valid=%b %h required 1 4b", rx_got, rx_byte); end
    checks++; if (gpio_out !== 4'h5) begin errors++; $display("FAIL write_gpio: got %h required 5", gpio_out); end
  endtask
  task automatic test_read();
    gpio_in = 2'b10;
    cycles(4);
    xact(8'h52, 1'b1);
    checks++; if ({rx_got, rx_byte} !== {1'b1, 8'h02}) begin errors++; $display("FAIL read_10: got valid=%b %h required 1 02", rx_got, rx_byte); end
    gpio_in = 2'b01;
    cycles(4);
    xact(8'h52, 1'b1);
    checks++; if ({rx_got, rx_byte} !== {1'b1, 8'h01}) begin errors++; $display("FAIL read_01: got valid=%b %h required 1 01", rx_got, rx_byte); end
    gpio_in = 2'b10;
  endtask
  task automatic test_err();
    xact(8'h33, 1'b1);
    checks++; if ({rx_got, rx_byte} !== {1'b1, 8'h3F}) begin errors++; $display("FAIL err_reply: got valid=%b %h required 1 3f", rx_got, rx_byte); end
  endtask
  task automatic test_framing();
    xact(8'h52, 1'b0);
    checks++; if (rx_got !== 1'b0) begin errors++; $display("FAIL frame_idle: got reply %h required none", rx_byte); end
    xact(8'h57, 1'b1);
    xact(8'h0C, 1'b0);
    checks++; if (rx_got !== 1'b0 || gpio_out !== 4'h5) begin errors++; $display("FAIL frame_wdata: got reply=%b gpio=%h required 0 5", rx_got, gpio_out); end
    xact(8'hA3, 1'b1);
    checks++; if ({rx_got, rx_byte, gpio_out} !== {1'b1, 8'h4B, 4'h3}) begin errors++; $display("FAIL frame_resume: got %b %h %h required 1 4b 3", rx_got, rx_byte, gpio_out); end
  endtask
  task automatic test_back_to_back();
    fork
      begin
        uart_send(8'h52, 1'b1);
        uart_send(8'h33, 1'b1);
      end
      uart_recv();
    join
    checks++; if ({rx_got, rx_byte} !== {1'b1, 8'h02}) begin errors++; $display("FAIL b2b_first: got valid=%b %h required 1 02", rx_got, rx_byte); end
    uart_recv();
    checks++; if (rx_got !== 1'b0) begin errors++; $display("FAIL b2b_dropped: got reply %h required none", rx_byte); end
    xact(8'h52, 1'b1);
    checks++; if ({rx_got, rx_byte} !== {1'b1, 8'h02}) begin errors++; $display("FAIL b2b_idle: got valid=%b %h required 1 02", rx_got, rx_byte); end
  endtask
  task automatic test_jtag();
    logic [3:0] pat = 4'b1101;
    trstb = 1'b1;
    cycles(5);
    for (int i = 0; i < 4; i++) begin
      tdi = pat[i];
      cycles(5);
      tck = 1'b1;
      cycles(5);
      tck = 1'b0;
      cycles(5);
      checks++; if (tdo !== pat[i]) begin errors++; $display("FAIL jtag_bit%0d: got %b required %b", i, tdo, pat[i]); end
    end
    trstb = 1'b0;
    cycles(5);
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL jtag_trst: got %b required 0", tdo); end
    trstb = 1'b1;
  endtask
  task automatic test_reset_mid();
    int t = 0;
    fork
      uart_send(8'h52, 1'b1);
      while (tx === 1'b1 && t < 20 * B) begin
        @(negedge clk);
        t++;
      end
    join
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_reply_start: got tx=%b required 0", tx); end
    cycles(3 * B);
    rst_n = 1'b0;
    #1;
    checks++; if ({tx, gpio_out} !== 5'b1_0000) begin errors++; $display("FAIL mid_reset: got %b required 10000", {tx, gpio_out}); end
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    xact(8'h52, 1'b1);
    checks++; if ({rx_got, rx_byte} !== {1'b1, 8'h02}) begin errors++; $display("FAIL mid_recover: got valid=%b %h required 1 02", rx_got, rx_byte); end
  endtask
  initial begin
    test_reset();
    test_ddr();
    test_write();
    test_read();
    test_err();
    test_framing();
    test_back_to_back();
    test_jtag();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/proc_subsystem.md
# proc_subsystem

Top-level processor-subsystem shell for the IGLOO2 M2GL025 board. It sits between the board pads and the on-chip logic. It provides:
- a UART command bridge to a small GPIO block;
- a single-clock-domain JTAG bypass;
- safe idle drive of the MDDR pad interface, with an optional DDR power-up sequence.

Everything runs on one system clock.

## Interface
Parameters:
- BAUD_DIV, 87: system-clock cycles per UART bit (10 MHz / 87 ≈ 115200 baud); minimum 8.
- DDR_RST_CYC, 2000: cycles from reset release to MDDR_RESET_N high.
- DDR_CKE_CYC, 5000: cycles from MDDR_RESET_N high to MDDR_CKE high.

Ports (one clock, CLK0_PAD; reset DEVRST_N is asynchronous and active-low):
- CLK0_PAD  in  1  system clock; all logic on its rising edge.
- DEVRST_N  in  1  asynchronous active-low reset.
- RX  in  1  UART receive, 8N1, idle high.
- TX  out  1  UART transmit, 8N1.
- GPIO_IN  in  2  general inputs.
- GPIO_OUT  out  4  general outputs.
- TCK, TMS, TDI, TRSTB  in  1 each  JTAG; TRSTB active-low.
- TDO  out  1  JTAG data out.
- MDDR_DQS_TMATCH_0_IN  in  1  DQS gate-training loop input.
- MDDR_DQS_TMATCH_0_OUT  out  1  loop output.
- MDDR_CLK, MDDR_CLK_N, MDDR_CKE, MDDR_CS_N, MDDR_ODT, MDDR_RAS_N, MDDR_CAS_N, MDDR_WE_N, MDDR_RESET_N  out  1 each  DDR control.
- MDDR_ADDR  out  16;  MDDR_BA  out  3.
- MDDR_DQ  inout  16;  MDDR_DQS, MDDR_DQS_N, MDDR_DM_RDQS  inout  2 each.

## Operation
- Reset values:
  - TX=1, TDO=0, GPIO_OUT=0.
  - MDDR_RESET_N=0, MDDR_CKE=0, MDDR_ODT=0.
  - MDDR_CS_N, MDDR_RAS_N, MDDR_CAS_N, MDDR_WE_N = 1.
  - MDDR_ADDR=0, MDDR_BA=0, MDDR_CLK=0, MDDR_CLK_N=1.
- All MDDR inouts are always high-Z.
- MDDR_DQS_TMATCH_0_OUT = MDDR_DQS_TMATCH_0_IN, combinational.
- UART RX:
  - RX passes through a 2-flop synchronizer.
  - A falling edge starts a frame; the start bit is re-checked at BAUD_DIV/2 and the frame is aborted if it reads high.
  - Data bits are sampled LSB-first every BAUD_DIV cycles thereafter.
  - A stop bit of 0 is a framing error; that byte is discarded.
- Command parser states: IDLE, WDATA, RESP.
  - IDLE: 'W' (0x57) goes to WDATA. 'R' (0x52) queues the reply {6'b0, GPIO_IN_sync}. Any other byte queues '?' (0x3F).
  - WDATA: the next byte, whatever its value, sets GPIO_OUT = byte[3:0] and queues 'K' (0x4B).
  - RESP: waits while TX is busy, then returns to IDLE.
- A byte received while a reply is queued or transmitting is dropped. The parser state does not change.
- GPIO_IN passes through a 2-flop synchronizer before it is read.
- JTAG bypass:
  - TCK is synchronized (2 flops) and its edges are detected in the CLK0_PAD domain.
  - On a TCK rising edge, TDI is captured into a 1-bit bypass flop.
  - On a TCK falling edge, TDO takes the bypass value.
  - Synchronized TRSTB low clears both flops to 0. TMS is ignored.
  - Supported TCK frequency is at most CLK0_PAD/8.

## Timing
- GPIO_OUT updates 1 cycle after the WDATA byte's stop-bit sample.
- The reply start bit begins within 2 cycles of the triggering stop-bit sample.
- A reply frame lasts 10×BAUD_DIV cycles.
- The RX-to-parser path has 2 cycles of synchronizer delay.
- TDO follows TDI by one TCK period plus at most 3 CLK0_PAD cycles.
- Assertion of DEVRST_N low at any point (including mid-frame or mid-reply) immediately restores all reset values. A partial frame is lost.

## Configuration
- Macro PROC_SUBSYSTEM_DDR_INIT_EN.
- Defined: after reset release, a counter deasserts MDDR_RESET_N after DDR_RST_CYC cycles, then sets MDDR_CKE=1 after DDR_CKE_CYC further cycles. MDDR_CLK/MDDR_CLK_N then toggle at CLK0_PAD/2, complementary. Command pins stay NOP (CS_N=1).
- Undefined: MDDR_RESET_N, MDDR_CKE and MDDR_CLK stay at their reset values permanently.

## Structure
- Package proc_subsystem_pkg holds:
  - command/reply byte constants: CMD_W, CMD_R, RSP_K, RSP_ERR;
  - the parser state enum (IDLE, WDATA, RESP).
- Sub-module proc_uart: RX and TX serializer with byte-valid / tx-start / tx-busy handshakes.
- Parser, GPIO, JTAG bypass and DDR sequencer are in the top level.

## Test plan
- Reset held for 10 cycles, then released -> all reset values hold; TX=1; MDDR inouts Z; TMATCH_OUT tracks TMATCH_IN.
- RX sends 0x57 then 0xA5 -> GPIO_OUT=0x5; TX returns 0x4B.
- GPIO_IN=2'b10, RX sends 0x52 -> TX returns 0x02.
- RX sends 0x33 -> 0x3F reply. A frame with stop bit 0 -> no reply and no state change.
- TCK at CLK/10 shifting TDI=1,0,1,1 -> TDO reproduces the pattern one TCK later. TRSTB=0 -> TDO=0.
- With PROC_SUBSYSTEM_DDR_INIT_EN, DDR_RST_CYC=20, DDR_CKE_CYC=30 -> MDDR_RESET_N rises at cycle 20 and CKE at cycle 50 after reset release; MDDR_CLK toggles thereafter.
